// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared encodings for the maze autoplayer
package maze_pkg;

    // Headings double as indices into a {left,bottom,right,top} open-wall vector
    localparam logic [1:0] HEAD_N = 2'd0;
    localparam logic [1:0] HEAD_E = 2'd1;
    localparam logic [1:0] HEAD_S = 2'd2;
    localparam logic [1:0] HEAD_W = 2'd3;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam int SEG_TOP    = 0;
    localparam int SEG_RIGHT  = 1;
    localparam int SEG_BOTTOM = 3;
    localparam int SEG_LEFT   = 4;
    localparam int SEG_WIN    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_PRESS,
        ST_RELEASE,
        ST_DONE,
        ST_STUCK
    } state_t;

    // One-hot game button for a heading
    function automatic logic [3:0] head_to_btn(input logic [1:0] h);
        logic [3:0] b;
        b = 4'b0000;
        case (h)
            HEAD_N:  b[BTN_UP]    = 1'b1;
            HEAD_E:  b[BTN_RIGHT] = 1'b1;
            HEAD_S:  b[BTN_DOWN]  = 1'b1;
            default: b[BTN_LEFT]  = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/maze_autoplayer_if.sv
// rtl/maze_autoplayer_if.sv - game-side wall/win input and button output bundle
interface maze_autoplayer_if;
    logic [7:0] game_out;
    logic [3:0] btn;

    modport master (input game_out, output btn);
    modport slave  (output game_out, input btn);
endinterface

// File: rtl/maze_move_chooser.sv
// rtl/maze_move_chooser.sv - right-hand wall-follower direction choice
module maze_move_chooser
    import maze_pkg::*;
(
    input  logic [1:0] i_heading,
    input  logic       i_top,
    input  logic       i_bottom,
    input  logic       i_left,
    input  logic       i_right,
    output logic [1:0] o_heading,
    output logic [3:0] o_btn,
    output logic       o_valid
);

    logic [3:0] w_open;
    logic [1:0] w_right_of;
    logic [1:0] w_straight;
    logic [1:0] w_left_of;
    logic [1:0] w_back;

    assign w_open[HEAD_N] = !i_top;
    assign w_open[HEAD_E] = !i_right;
    assign w_open[HEAD_S] = !i_bottom;
    assign w_open[HEAD_W] = !i_left;

    // Modular 2-bit turns relative to the current heading
    assign w_right_of = i_heading + 2'd1;
    assign w_straight = i_heading;
    assign w_left_of  = i_heading - 2'd1;
    assign w_back     = i_heading + 2'd2;

    // First open direction in right, straight, left, back order
    always_comb begin
        o_heading = i_heading;
        o_valid   = 1'b1;
        if (w_open[w_right_of])      o_heading = w_right_of;
        else if (w_open[w_straight]) o_heading = w_straight;
        else if (w_open[w_left_of])  o_heading = w_left_of;
        else if (w_open[w_back])     o_heading = w_back;
        else                         o_valid   = 1'b0;
        o_btn = o_valid ? head_to_btn(o_heading) : 4'b0000;
    end

endmodule

// File: rtl/maze_autoplayer.sv
// rtl/maze_autoplayer.sv - autonomous wall-following player for the micro-maze game
module maze_autoplayer
    import maze_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_STEPS     = 1023,
    parameter int INIT_HEADING  = 1
) (
    input  logic              clk,
    input  logic              rst,
    maze_autoplayer_if.master game,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stuck,
    output logic              o_error,
    output logic [9:0]        o_steps
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [9:0] STEP_LIMIT  = 10'(MAX_STEPS);
    localparam logic [1:0] HEAD_INIT   = 2'(INIT_HEADING);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_btn;
    logic [1:0] r_heading;
    logic [9:0] r_steps;
    logic [7:0] r_settle_cnt;
    logic       r_done;
    logic       r_stuck;
    logic       r_error;

    logic       w_win;
    logic       w_dup_bad;
    logic       w_busy;
    logic       w_start_run;
    logic [1:0] w_choice_heading;
    logic [3:0] w_choice_btn;
    logic       w_choice_valid;

    assign w_win     = game.game_out[SEG_WIN];
    assign w_dup_bad = (game.game_out[1] ^ game.game_out[2]) |
                       (game.game_out[4] ^ game.game_out[5]) |
                       (game.game_out[6] ^ game.game_out[7]);
    assign w_busy    = (r_state == ST_SETTLE) || (r_state == ST_DECIDE) ||
                       (r_state == ST_PRESS)  || (r_state == ST_RELEASE);
    // A start only counts when not busy and not overridden by abort
    assign w_start_run = i_start && !i_abort && !w_busy;

    maze_move_chooser u_chooser (
        .i_heading (r_heading),
        .i_top     (game.game_out[SEG_TOP]),
        .i_bottom  (game.game_out[SEG_BOTTOM]),
        .i_left    (game.game_out[SEG_LEFT]),
        .i_right   (game.game_out[SEG_RIGHT]),
        .o_heading (w_choice_heading),
        .o_btn     (w_choice_btn),
        .o_valid   (w_choice_valid)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; win outranks the step budget, abort outranks everything
    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_STUCK: if (i_start) w_next_state = ST_SETTLE;
                ST_SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_next_state = ST_DECIDE;
                ST_DECIDE: begin
                    if (w_win)                       w_next_state = ST_DONE;
                    else if (r_steps == STEP_LIMIT)  w_next_state = ST_STUCK;
                    else if (w_choice_valid)         w_next_state = ST_PRESS;
                    else                             w_next_state = ST_STUCK;
                end
                ST_PRESS:   w_next_state = ST_RELEASE;
                ST_RELEASE: w_next_state = ST_SETTLE;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    // Registered buttons, heading, step counter, settle timer and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn        <= 4'b0000;
            r_heading    <= HEAD_INIT;
            r_steps      <= 10'd0;
            r_settle_cnt <= 8'd0;
            r_done       <= 1'b0;
            r_stuck      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_btn <= (w_next_state == ST_PRESS) ? w_choice_btn : 4'b0000;

            if ((r_state == ST_SETTLE) && (w_next_state == ST_SETTLE))
                r_settle_cnt <= r_settle_cnt + 8'd1;
            else
                r_settle_cnt <= 8'd0;

            if (w_start_run) begin
                r_heading <= HEAD_INIT;
                r_steps   <= 10'd0;
                r_done    <= 1'b0;
                r_stuck   <= 1'b0;
                r_error   <= 1'b0;
            end else begin
                if (w_next_state == ST_PRESS) begin
                    r_heading <= w_choice_heading;
                    if (r_steps != 10'h3FF) r_steps <= r_steps + 10'd1;
                end
                if (i_abort) begin
                    r_done  <= 1'b0;
                    r_stuck <= 1'b0;
                end else if (r_state == ST_DECIDE) begin
                    if (w_next_state == ST_DONE)  r_done  <= 1'b1;
                    if (w_next_state == ST_STUCK) r_stuck <= 1'b1;
                end
                if (w_busy && w_dup_bad) r_error <= 1'b1;
            end
        end
    end

    assign game.btn = r_btn;
    assign o_busy   = w_busy;
    assign o_done   = r_done;
    assign o_stuck  = r_stuck;
    assign o_error  = r_error;
    assign o_steps  = r_steps;

endmodule
